// File: rtl/seg_scan_ctrl_if.sv
// Pin bundle between the time-keeping logic (master) and the display scanner (slave).
// Level-sampled signals only: the scanner shadows the inputs once per frame, so there is no valid/ready handshake.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   bcd_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic [NUM_DIGITS-1:0]     blink_mask;
  logic                      blank_lz;
  logic [3:0]                brightness;
  logic [7:0]                seg;
  logic [NUM_DIGITS-1:0]     digits;
  logic                      frame_tick;

  modport master (
    output enable, bcd_in, dp_in, blink_mask, blank_lz, brightness,
    input  seg, digits, frame_tick
  );

  modport slave (
    input  enable, bcd_in, dp_in, blink_mask, blank_lz, brightness,
    output seg, digits, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness, dp, leading-zero blanking
// and blink; inputs are shadowed once per frame so a frame never shows a mix of old and new values.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int SUB_N = SCAN_DIV / 16;
  localparam int SW    = $clog2(SUB_N);
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int BW    = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SUB_N - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [SW-1:0]                 sub_cnt;
  logic [3:0]                    phase;
  logic [IW-1:0]                 idx;
  logic [BW-1:0]                 blink_cnt;
  logic                          blink_ph;
  logic                          loaded;
  logic [NUM_DIGITS-1:0][3:0]    sh_bcd;
  logic [NUM_DIGITS-1:0]         sh_dp;
  logic [NUM_DIGITS-1:0]         sh_blink;
  logic                          sh_blz;
  logic [3:0]                    sh_bri;
  logic                          sh_en;
  logic [7:0]                    seg_q;
  logic [NUM_DIGITS-1:0]         digits_q;
  logic                          tick_q;

  logic                          slot_end;
  logic                          frame_end;
  logic                          load;
  logic                          lit;
  logic                          all_zero;
  logic [NUM_DIGITS-1:0]         lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (sub_cnt == SUB_LAST) && (phase == 4'hF);
  assign frame_end = slot_end && (idx == IDX_LAST);
  // The first edge after reset only captures inputs; scanning starts from slot 0 on the next edge.
  assign load      = frame_end || !loaded;

  // A digit is a leading zero when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero && (sh_bcd[i] == 4'h0);
      lz_blank[i] = sh_blz && all_zero;
    end
  end

  assign lit = sh_en && !lz_blank[idx] && !(blink_ph && sh_blink[idx]) && (phase <= sh_bri);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt   <= '0;
      phase     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      loaded    <= 1'b0;
      sh_bcd    <= '0;
      sh_dp     <= '0;
      sh_blink  <= '0;
      sh_blz    <= 1'b0;
      sh_bri    <= '0;
      sh_en     <= 1'b0;
      seg_q     <= 8'hFF;
      digits_q  <= '1;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= load;
      if (load) begin
        loaded   <= 1'b1;
        sh_bcd   <= bus.bcd_in;
        sh_dp    <= bus.dp_in;
        sh_blink <= bus.blink_mask;
        sh_blz   <= bus.blank_lz;
        sh_bri   <= bus.brightness;
        sh_en    <= bus.enable;
      end
      if (loaded) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= '0;
          phase   <= phase + 4'd1;
          if (phase == 4'hF) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (lit) begin
        seg_q    <= {~sh_dp[idx], decode(sh_bcd[idx])};
        digits_q <= ~(NUM_DIGITS'(1) << idx);
      end else begin
        seg_q    <= 8'hFF;
        digits_q <= '1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.digits     = digits_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 32-cycle slots, 2-frame blink half-period): per-slot expectations
// are queued when inputs are driven and checked as each slot of the target frame completes.
module tb_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int SD = 32;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic [3:0]      blink;
    logic            blz;
    logic [3:0]      bri;
    logic            en;
    logic [3:0][7:0] exp_seg;   // {d3,d2,d1,d0}; 8'hFF means the digit stays dark
  } vec_t;

  typedef struct packed {
    logic [15:0] frame;
    logic [2:0]  digit;
    logic [6:0]  cnt;
    logic [7:0]  seg;
  } exp_t;

  logic clk;
  logic rst;
  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus();

  seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  vec_t vecs[12];
  vec_t blink_on;
  vec_t blink_off;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    bus.bcd_in     = v.bcd;
    bus.dp_in      = v.dp;
    bus.blink_mask = v.blink;
    bus.blank_lz   = v.blz;
    bus.brightness = v.bri;
    bus.enable     = v.en;
  endtask

  task automatic push_vec(input vec_t v, input int frame);
    exp_t e;
    for (int d = 0; d < N; d++) begin
      e.frame = 16'(frame);
      e.digit = 3'(d);
      e.seg   = v.exp_seg[d];
      e.cnt   = (v.exp_seg[d] == 8'hFF) ? 7'd0 : 7'(2 * (int'(v.bri) + 1));
      exp_q.push_back(e);
    end
  endtask

  // scoreboard / monitor: t counts samples since the last frame_tick; slot d covers t = 1+32d .. 32+32d
  int          frame_no = 0;
  int          t = 0;
  bit          in_frame = 0;
  int          lows, first_off, last_off;
  logic [7:0]  seg_seen;
  bit          bad_anode, seg_var, dark_bad;

  task automatic clear_acc();
    lows = 0; first_off = -1; last_off = -1; seg_seen = 8'hFF;
    bad_anode = 0; seg_var = 0; dark_bad = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      frame_no = 0; t = 0; in_frame = 0;
      clear_acc();
    end else begin
      check("anodes_onehot", ($countones(~bus.digits) > 1) ? 32'd1 : 32'd0, 32'd0);
      if (in_frame) begin
        int slot, off;
        logic [3:0] exp_an;
        t++;
        slot = (t - 1) / SD;
        off  = (t - 1) % SD;
        if (slot < N) begin
          exp_an = ~(4'b0001 << slot);
          if (bus.digits != 4'hF) begin
            if (lows == 0) begin first_off = off; seg_seen = bus.seg; end
            else if (bus.seg != seg_seen) seg_var = 1;
            lows++;
            last_off = off;
            if (bus.digits != exp_an) bad_anode = 1;
          end else if (bus.seg != 8'hFF) begin
            dark_bad = 1;
          end
          if (off == SD - 1) begin
            if (exp_q.size() > 0 && int'(exp_q[0].frame) == frame_no && int'(exp_q[0].digit) == slot) begin
              exp_t e;
              e = exp_q.pop_front();
              check($sformatf("lit_cycles f%0d d%0d", frame_no, slot), lows, e.cnt);
              if (e.cnt > 0) begin
                check($sformatf("window_start f%0d d%0d", frame_no, slot), first_off, 0);
                check($sformatf("window_end f%0d d%0d", frame_no, slot), last_off, int'(e.cnt) - 1);
                check($sformatf("seg f%0d d%0d", frame_no, slot), seg_seen, e.seg);
              end
              check($sformatf("pins_consistent f%0d d%0d", frame_no, slot),
                    {bad_anode, seg_var, dark_bad}, 3'b000);
            end else if (exp_q.size() > 0 && (int'(exp_q[0].frame) < frame_no ||
                         (int'(exp_q[0].frame) == frame_no && int'(exp_q[0].digit) < slot))) begin
              check("slot_order", exp_q[0].frame, frame_no);
              void'(exp_q.pop_front());
            end
            clear_acc();
          end
        end
      end
      if (bus.frame_tick) begin
        if (in_frame) check("frame_len", t, N * SD);
        frame_no++;
        t = 0;
        in_frame = 1;
        clear_acc();
      end
    end
  end

  task automatic wait_frame();
    int f0, n;
    f0 = frame_no;
    n  = 0;
    while (frame_no == f0 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) check("tick_timeout", frame_no, f0 + 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 4'h0,    4'h0, 1'b0, 4'hF, 1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1]  = '{16'h1234, 4'h0,    4'h0, 1'b0, 4'h3, 1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[2]  = '{16'h0007, 4'h0,    4'h0, 1'b1, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[3]  = '{16'h0000, 4'h0,    4'h0, 1'b1, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4]  = '{16'h0000, 4'h0,    4'h0, 1'b0, 4'hF, 1'b1, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[5]  = '{16'h1234, 4'h0,    4'h0, 1'b0, 4'hF, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[6]  = '{16'h8888, 4'b0100, 4'h0, 1'b0, 4'hF, 1'b1, {8'h80, 8'h00, 8'h80, 8'h80}};
    vecs[7]  = '{16'h0A0F, 4'hF,    4'h0, 1'b1, 4'hF, 1'b1, {8'hFF, 8'h08, 8'h40, 8'h0E}};
    vecs[8]  = '{16'hBCDE, 4'h0,    4'h0, 1'b0, 4'h0, 1'b1, {8'h83, 8'hC6, 8'hA1, 8'h86}};
    vecs[9]  = '{16'h5678, 4'h0,    4'h0, 1'b0, 4'h7, 1'b1, {8'h92, 8'h82, 8'hF8, 8'h80}};
    vecs[10] = '{16'h9000, 4'h0,    4'h0, 1'b1, 4'hF, 1'b1, {8'h90, 8'hC0, 8'hC0, 8'hC0}};
    vecs[11] = '{16'h0090, 4'h0,    4'h0, 1'b1, 4'hF, 1'b1, {8'hFF, 8'hFF, 8'h90, 8'hC0}};
    blink_on  = '{16'h1234, 4'b0100, 4'b0001, 1'b0, 4'hF, 1'b1, {8'hF9, 8'h24, 8'hB0, 8'h99}};
    blink_off = '{16'h1234, 4'b0100, 4'b0001, 1'b0, 4'hF, 1'b1, {8'hF9, 8'h24, 8'hB0, 8'hFF}};

    // reset state, then first load on the first edge after release
    rst = 1'b0;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check("reset_seg", bus.seg, 8'hFF);
    check("reset_digits", bus.digits, 4'hF);
    check("reset_tick", bus.frame_tick, 1'b0);
    push_vec(vecs[0], 1);
    #2 rst = 1'b1;
    @(negedge clk);
    check("first_tick", bus.frame_tick, 1'b1);

    // table: each vector is driven mid-frame and must appear only in the following frame
    for (int i = 1; i < 12; i++) begin
      wait_frame();
      repeat (40) @(negedge clk);
      drive(vecs[i]);
      push_vec(vecs[i], frame_no + 1);
    end
    wait_drain(1000);

    // async reset in the middle of digit 1's lit window
    repeat (40) @(negedge clk);
    check("pre_reset_lit", bus.digits, 4'b1101);
    #2 rst = 1'b0;
    #1;
    check("async_seg", bus.seg, 8'hFF);
    check("async_digits", bus.digits, 4'hF);
    check("async_tick", bus.frame_tick, 1'b0);

    // blink + dp after restart: digit 0 dark in frames 3-4, lit in 1-2 and 5-6
    drive(blink_on);
    for (int f = 1; f <= 6; f++) push_vec((f == 3 || f == 4) ? blink_off : blink_on, f);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("restart_tick", bus.frame_tick, 1'b1);
    wait_drain(1200);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
